// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants and the signed result type passed from traditional_conv downstream.
// Geometry: conv map edge CONV_N and pooled edge POOL_N derive from the image/kernel sizes.
package cnn_pkg;
   localparam int WORD_LENGTH        = 8;
   localparam int DOUBLE_WORD_LENGTH = 16;
   localparam int KERNEL_SIZE        = 5;
   localparam int IMAGE_SIZE         = 36;
   localparam int CONV_N             = IMAGE_SIZE - KERNEL_SIZE + 1;
   localparam int POOL_N             = CONV_N / 2;

   typedef logic signed [DOUBLE_WORD_LENGTH-1:0] conv_result_t;
endpackage

// File: rtl/pool_row_buffer.sv
// Half-row buffer holding the horizontal maxima of an even conv row until the odd row arrives.
// Synchronous write, combinational read, cleared by reset.
module pool_row_buffer #(
   parameter int depth  = 16,
   parameter int width  = 16,
   parameter int addr_w = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [addr_w-1:0] wr_addr,
   input  logic [width-1:0]  wr_data,
   input  logic [addr_w-1:0] rd_addr,
   output logic [width-1:0]  rd_data
);
   logic [width-1:0] mem [depth];

   genvar gi;
   generate
      for (gi = 0; gi < depth; gi++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               mem[gi] <= '0;
            else if (wr_en && (wr_addr == addr_w'(gi)))
               mem[gi] <= wr_data;
         end
      end
   endgenerate

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling over a raster-order conv result stream.
// Even rows park pair maxima in the row buffer; odd rows combine with them and emit one pixel.
module relu_maxpool_2x2
   import cnn_pkg::*;
#(
   parameter int word_length        = WORD_LENGTH,
   parameter int double_word_length = DOUBLE_WORD_LENGTH,
   parameter int kernel_size        = KERNEL_SIZE,
   parameter int image_size         = IMAGE_SIZE
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   input  logic signed [double_word_length-1:0] data_in,
   output logic signed [double_word_length-1:0] data_out,
   output logic                                 out_valid,
   output logic                                 out_last
);
   localparam int conv_n = image_size - kernel_size + 1;
   localparam int pool_n = conv_n / 2;
   localparam int cnt_w  = $clog2(conv_n);
   localparam int addr_w = cnt_w - 1;
   localparam logic [cnt_w-1:0] last_idx = cnt_w'(conv_n - 1);

   generate
      if ((conv_n % 2) != 0 || conv_n < 4 || word_length > double_word_length) begin : g_bad_cfg
         $error("relu_maxpool_2x2: conv map edge must be even and >= 4");
      end
   endgenerate

   logic [cnt_w-1:0]                    col, row;
   logic signed [double_word_length-1:0] h_hold;
   logic signed [double_word_length-1:0] r, h_max, p, row_max;
   logic [double_word_length-1:0]        rd_data;
   logic                                 wr_en;

   // After ReLU every operand is non-negative, so the signed compares never see a sign flip.
   always_comb begin
      r       = data_in[double_word_length-1] ? '0 : data_in;
      h_max   = (r > h_hold) ? r : h_hold;
      row_max = $signed(rd_data);
      p       = (row_max > h_max) ? row_max : h_max;
      wr_en   = in_valid && col[0] && !row[0];
   end

   pool_row_buffer #(
      .depth  (pool_n),
      .width  (double_word_length),
      .addr_w (addr_w)
   ) u_row_buffer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (col[cnt_w-1:1]),
      .wr_data (h_max),
      .rd_addr (col[cnt_w-1:1]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         h_hold    <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         if (in_valid) begin
            if (col == last_idx) begin
               col <= '0;
               row <= (row == last_idx) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end

            if (!col[0]) begin
               h_hold <= r;
            end else if (row[0]) begin
               data_out  <= p;
               out_valid <= 1'b1;
               out_last  <= (row == last_idx) && (col == last_idx);
            end
         end
      end
   end
endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Directed bench for relu_maxpool_2x2: constant, negative, ramp, gapped, extreme and reset-recovery frames.
// Pulse timing is tracked from the bench's own raster position; pooled values come from hand formulas.
module tb_relu_maxpool_2x2;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        out_valid;
   logic        out_last;

   logic        cur_odd = 1'b0;
   logic        cur_last = 1'b0;
   logic        exp_valid, exp_last;
   logic [15:0] got_q [$];
   int          last_cnt = 0;
   int          checks = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   relu_maxpool_2x2 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_last  (out_last)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs === expv)
         passed++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
   endtask

   // A pulse is due one cycle after an accepted beat at odd row / odd col.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_valid <= 1'b0;
         exp_last  <= 1'b0;
      end else begin
         exp_valid <= in_valid && cur_odd;
         exp_last  <= in_valid && cur_last;
      end
   end

   always @(negedge clk) begin
      if (out_valid || exp_valid)
         check("out_valid", 32'(out_valid), 32'(exp_valid));
      if (out_valid) begin
         got_q.push_back(data_out);
         check("out_last", 32'(out_last), 32'(exp_last));
         if (out_last) last_cnt++;
      end else if (out_last) begin
         check("last_without_valid", 32'(out_last), 32'd0);
      end
   end

   function automatic logic [15:0] beat_val(input int mode, input int r, input int c);
      case (mode)
         0: return 16'h0005;
         1: return 16'hFFFD;
         2: return 16'(r * 32 + c);
         3: begin
            if (r == 0 && c == 0) return 16'h8000;
            if (r == 0 && c == 1) return 16'h0007;
            if (r == 1 && c == 0) return 16'h7FFF;
            if (r == 1 && c == 1) return 16'h0001;
            if (r < 2 && (c == 2 || c == 3)) return 16'h8000;
            return 16'h0000;
         end
         default: return 16'h7000;
      endcase
   endfunction

   function automatic logic [15:0] exp_out(input int mode, input int k);
      int pr = k / 16;
      int pc = k % 16;
      case (mode)
         0: return 16'h0005;
         1: return 16'h0000;
         2: return 16'((2 * pr + 1) * 32 + 2 * pc + 1);
         default: return (k == 0) ? 16'h7FFF : 16'h0000;
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         cur_odd  = 1'b0;
         cur_last = 1'b0;
      end
   endtask

   task automatic send_beats(input int mode, input int nbeats, input int max_gap);
      for (int i = 0; i < nbeats; i++) begin
         int r = (i / 32) % 32;
         int c = i % 32;
         @(negedge clk);
         in_valid = 1'b1;
         data_in  = beat_val(mode, r, c);
         cur_odd  = (r % 2 == 1) && (c % 2 == 1);
         cur_last = (r == 31) && (c == 31);
         if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic run_frames(input string name, input int mode, input int nframes, input int max_gap);
      int n = 256 * nframes;
      got_q.delete();
      last_cnt = 0;
      send_beats(mode, 1024 * nframes, max_gap);
      idle(3);
      check({name, ":count"}, got_q.size(), n);
      check({name, ":last_pulses"}, last_cnt, nframes);
      for (int k = 0; k < got_q.size() && k < n; k++)
         check($sformatf("%s[%0d]", name, k), {16'h0, got_q[k]}, {16'h0, exp_out(mode, k % 256)});
      $display("test %s: %0d outputs, %0d last pulses", name, got_q.size(), last_cnt);
   endtask

   initial begin
      idle(2);
      check("reset:data_out", {16'h0, data_out}, 32'd0);
      check("reset:out_valid", 32'(out_valid), 32'd0);
      check("reset:out_last", 32'(out_last), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      run_frames("constant", 0, 1, 0);
      run_frames("negative", 1, 1, 0);
      run_frames("ramp", 2, 1, 0);
      run_frames("gapped_ramp", 2, 1, 3);
      run_frames("extremes", 3, 1, 0);

      // Partial frame of large values, then reset must restart at position (0,0).
      send_beats(4, 100, 0);
      idle(1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midreset:data_out", {16'h0, data_out}, 32'd0);
      rst = 1'b0;
      run_frames("reset_two_ramps", 2, 2, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
